// File: rtl/cluster_unpacker.sv
// cluster_unpacker
//   Rebuilds the VPF hit map from the cluster words (address + size) that arrive
//   one per clock over an 8-phase frame. One reconstructed map is emitted per
//   completed frame with a single-cycle valid strobe, plus frame diagnostics.
//
//   Optional feature macro: CLUSTER_SIZE_EXPAND_EN
//     defined     : each cluster sets strips adr..adr+size, clipped at the end of
//                   adr's eta partition
//     not defined : size field ignored, only strip adr is set
//
// Ports
//   clock          in   fabric clock
//   global_reset   in   synchronous, active-high reset
//   frame_start    in   marks the phase-0 cluster word of a frame
//   cluster_in     in   {size, adr}
//   cluster_valid  in   cluster_in holds a word this cycle
//   vpfs_out       out  reconstructed hit map, held until the next frame completes
//   vpfs_valid     out  one-cycle strobe: vpfs_out updated
//   cluster_cnt    out  real (non-null) clusters in the vpfs_out frame
//   frame_err      out  sticky: frame aborted by early frame_start or missing word
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame open; frame_start here is phase 0 of a new frame
// ACCUM | frame open, r_phase holds the current phase (1..MXCLUSTERS-1)

module cluster_unpacker #(
  parameter int MXCLUSTERS = 8,
  parameter int MXADRB     = 11,
  parameter int MXCNTB     = 3,
  parameter int NSTRIPS    = 1536,
  parameter int PARTSIZE   = 192
) (
  input  logic                     clock,
  input  logic                     global_reset,
  input  logic                     frame_start,
  input  logic [MXADRB+MXCNTB-1:0] cluster_in,
  input  logic                     cluster_valid,
  output logic [NSTRIPS-1:0]       vpfs_out,
  output logic                     vpfs_valid,
  output logic [3:0]               cluster_cnt,
  output logic                     frame_err
);

  localparam int               PHW        = $clog2(MXCLUSTERS);
  localparam logic [PHW-1:0]   LAST_PHASE = PHW'(MXCLUSTERS - 1);
  localparam logic [MXADRB-1:0] ADR_LIMIT = MXADRB'(NSTRIPS);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]         r_state;
  logic [PHW-1:0]     r_phase;
  logic [NSTRIPS-1:0] r_acc;
  logic [3:0]         r_cnt;
  logic [NSTRIPS-1:0] r_vpfs_out;
  logic               r_vpfs_valid;
  logic [3:0]         r_cluster_cnt;
  logic               r_frame_err;

  logic [MXADRB-1:0]  w_adr;
  logic [MXCNTB-1:0]  w_size;
  logic               w_hit;
  logic               w_in_frame;
  logic               w_err_evt;
  logic [NSTRIPS-1:0] w_mask;

  assign w_adr  = cluster_in[MXADRB-1:0];
  assign w_size = cluster_in[MXADRB+MXCNTB-1:MXADRB];

  // Null addresses (0x7FE/0x7FF) fall above ADR_LIMIT and are dropped here.
  assign w_hit      = cluster_valid && (w_adr < ADR_LIMIT);
  assign w_in_frame = frame_start || (r_state == S_ACCUM);

  // A frame_start while a frame is open means the previous frame was cut short;
  // in ACCUM the phase is always 1..7 so any frame_start there is an abort.
  assign w_err_evt = (frame_start && (r_state == S_ACCUM)) ||
                     (w_in_frame && !cluster_valid);

`ifdef CLUSTER_SIZE_EXPAND_EN
  logic [MXADRB-1:0] w_off;
  logic [MXADRB-1:0] w_idx;

  assign w_off = w_adr % MXADRB'(PARTSIZE);

  // Strips adr..adr+size, stopping at the last strip of adr's partition.
  always_comb begin
    w_mask = '0;
    w_idx  = '0;
    for (int k = 0; k < (1 << MXCNTB); k++) begin
      w_idx = w_adr + MXADRB'(k);
      if (w_hit && (k <= int'(w_size)) && ((int'(w_off) + k) < PARTSIZE))
        w_mask[w_idx] = 1'b1;
    end
  end
`else
  logic w_unused_size;
  assign w_unused_size = ^w_size;

  always_comb begin
    w_mask = '0;
    if (w_hit) w_mask[w_adr] = 1'b1;
  end
`endif

  always_ff @(posedge clock) begin
    if (global_reset) begin
      r_state       <= S_IDLE;
      r_phase       <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_vpfs_out    <= '0;
      r_vpfs_valid  <= 1'b0;
      r_cluster_cnt <= '0;
      r_frame_err   <= 1'b0;
    end else begin
      r_vpfs_valid <= 1'b0;
      if (w_err_evt) r_frame_err <= 1'b1;

      if (frame_start) begin
        // Phase 0: start fresh, discarding any partial frame.
        r_acc   <= w_mask;
        r_cnt   <= 4'(w_hit);
        r_phase <= PHW'(1);
        r_state <= S_ACCUM;
      end else if (r_state == S_ACCUM) begin
        if (r_phase == LAST_PHASE) begin
          r_vpfs_out    <= r_acc | w_mask;
          r_cluster_cnt <= r_cnt + 4'(w_hit);
          r_vpfs_valid  <= 1'b1;
          r_acc         <= '0;
          r_cnt         <= '0;
          r_phase       <= '0;
          r_state       <= S_IDLE;
        end else begin
          r_acc   <= r_acc | w_mask;
          r_cnt   <= r_cnt + 4'(w_hit);
          r_phase <= r_phase + PHW'(1);
        end
      end
    end
  end

  assign vpfs_out    = r_vpfs_out;
  assign vpfs_valid  = r_vpfs_valid;
  assign cluster_cnt = r_cluster_cnt;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_cluster_unpacker.sv
module tb_cluster_unpacker;

  logic          clock = 1'b0;
  logic          global_reset;
  logic          frame_start;
  logic [13:0]   cluster_in;
  logic          cluster_valid;
  logic [1535:0] vpfs_out;
  logic          vpfs_valid;
  logic [3:0]    cluster_cnt;
  logic          frame_err;

  cluster_unpacker dut (
    .clock        (clock),
    .global_reset (global_reset),
    .frame_start  (frame_start),
    .cluster_in   (cluster_in),
    .cluster_valid(cluster_valid),
    .vpfs_out     (vpfs_out),
    .vpfs_valid   (vpfs_valid),
    .cluster_cnt  (cluster_cnt),
    .frame_err    (frame_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_armed = 0;
  bit            m_inframe;
  int            m_seen;
  logic [13:0]   m_words[$];
  bit            m_valid;
  int            m_cnt;
  bit            m_err;
  bit [1535:0]   m_map;

  function automatic void build_map(output bit [1535:0] map, output int cnt);
    map = '0;
    cnt = 0;
    foreach (m_words[i]) begin
      int adr, sz, hi, pend;
      adr = int'(m_words[i][10:0]);
      sz  = int'(m_words[i][13:11]);
      if (adr < 1536) begin
        cnt++;
`ifdef CLUSTER_SIZE_EXPAND_EN
        hi = adr + sz;
`else
        hi = adr;
`endif
        pend = (adr / 192) * 192 + 191;
        if (hi > pend) hi = pend;
        for (int s = adr; s <= hi; s++) map[s] = 1'b1;
      end
    end
  endfunction

  always @(posedge clock) begin
    if (global_reset) begin
      m_armed = 1; m_inframe = 0; m_seen = 0; m_words.delete();
      m_valid = 0; m_cnt = 0; m_err = 0; m_map = '0;
    end else begin
      m_valid = 0;
      if (frame_start) begin
        if (m_inframe) m_err = 1;
        m_inframe = 1; m_seen = 0; m_words.delete();
      end
      if (m_inframe) begin
        if (!cluster_valid) m_err = 1;
        else m_words.push_back(cluster_in);
        m_seen++;
        if (m_seen == 8) begin
          build_map(m_map, m_cnt);
          m_valid = 1;
          m_inframe = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_armed) begin
      chk("model_valid", 32'(vpfs_valid), 32'(m_valid));
      chk("model_cnt",   32'(cluster_cnt), 32'(m_cnt));
      chk("model_err",   32'(frame_err), 32'(m_err));
      n_checks++;
      if (vpfs_out !== m_map) begin
        n_fail++;
        $display("FAIL model_map got_ones=%0d exp_ones=%0d at %0t",
                 $countones(vpfs_out), $countones(m_map), $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [13:0] fw [8];
  bit          fv [8];

  function automatic logic [13:0] mk(input int adr, input int sz);
    return {3'(sz), 11'(adr)};
  endfunction

  task automatic drive(input bit fs, input bit v, input logic [13:0] w);
    @(negedge clock);
    frame_start = fs; cluster_valid = v; cluster_in = w;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 14'd0);
  endtask

  task automatic send_frame();
    for (int i = 0; i < 8; i++) drive(i == 0, fv[i], fw[i]);
  endtask

  task automatic fill(input int adr, input int sz);
    for (int i = 0; i < 8; i++) begin fw[i] = mk(adr, sz); fv[i] = 1; end
  endtask

  initial begin
    global_reset = 1; frame_start = 0; cluster_valid = 0; cluster_in = '0;
    repeat (3) @(negedge clock);
    chk("rst_valid", 32'(vpfs_valid), 0);
    chk("rst_cnt",   32'(cluster_cnt), 0);
    chk("rst_err",   32'(frame_err), 0);
    chk("rst_map",   $countones(vpfs_out), 0);
    global_reset = 0;
    idle(); idle();

    // Mixed addresses including partition edges and nulls.
    fw[0] = mk(0,0);   fw[1] = mk(5,0);    fw[2] = mk(191,0);   fw[3] = mk(192,0);
    fw[4] = mk(700,0); fw[5] = mk(1535,0); fw[6] = mk(11'h7FE,0); fw[7] = mk(11'h7FF,0);
    for (int i = 0; i < 8; i++) fv[i] = 1;
    send_frame();
    idle();
    chk("t1_valid", 32'(vpfs_valid), 1);
    chk("t1_cnt",   32'(cluster_cnt), 6);
    chk("t1_ones",  $countones(vpfs_out), 6);
    chk("t1_bits",  32'({vpfs_out[0], vpfs_out[5], vpfs_out[191], vpfs_out[192],
                         vpfs_out[700], vpfs_out[1535]}), 32'h3F);
    chk("t1_err",   32'(frame_err), 0);
    idle();
    chk("t1_strobe_once", 32'(vpfs_valid), 0);

    // All-null frame still strobes.
    fill(11'h7FF, 0);
    send_frame(); idle();
    chk("t2_valid", 32'(vpfs_valid), 1);
    chk("t2_cnt",   32'(cluster_cnt), 0);
    chk("t2_ones",  $countones(vpfs_out), 0);

    // Duplicates OR together but each counts.
    fill(100, 0);
    send_frame(); idle();
    chk("t3_cnt",   32'(cluster_cnt), 8);
    chk("t3_ones",  $countones(vpfs_out), 1);
    chk("t3_bit",   32'(vpfs_out[100]), 1);

    // Back-to-back frames, no leakage between them.
    fill(300, 0); send_frame();
    fill(400, 0); send_frame();
    fill(500, 0); send_frame();
    idle();
    chk("t5_cnt",   32'(cluster_cnt), 8);
    chk("t5_ones",  $countones(vpfs_out), 1);
    chk("t5_bit",   32'(vpfs_out[500]), 1);
    chk("t5_err",   32'(frame_err), 0);

    // Missing word at phase 3: frame still completes, error latched.
    for (int i = 0; i < 8; i++) begin fw[i] = mk(20 + i, 0); fv[i] = (i != 3); end
    send_frame(); idle();
    chk("miss_valid", 32'(vpfs_valid), 1);
    chk("miss_cnt",   32'(cluster_cnt), 7);
    chk("miss_err",   32'(frame_err), 1);
    idle();

    // Abort at phase 4: new frame holds only its own clusters.
    drive(1, 1, mk(900,0)); drive(0, 1, mk(901,0));
    drive(0, 1, mk(902,0)); drive(0, 1, mk(903,0));
    for (int i = 0; i < 8; i++) begin fw[i] = mk(40 + i, 0); fv[i] = 1; end
    send_frame(); idle();
    chk("t4_valid", 32'(vpfs_valid), 1);
    chk("t4_cnt",   32'(cluster_cnt), 8);
    chk("t4_ones",  $countones(vpfs_out), 8);
    chk("t4_old",   32'(vpfs_out[900]), 0);
    chk("t4_err",   32'(frame_err), 1);
    idle();

    // Size expansion with partition clipping.
    fill(11'h7FF, 0);
    fw[0] = mk(189, 7); fw[1] = mk(10, 3);
    send_frame(); idle();
    chk("t6_cnt", 32'(cluster_cnt), 2);
`ifdef CLUSTER_SIZE_EXPAND_EN
    chk("t6_ones", $countones(vpfs_out), 7);
    chk("t6_clip", 32'(vpfs_out[192]), 0);
    chk("t6_bits", 32'({vpfs_out[189], vpfs_out[191], vpfs_out[10], vpfs_out[13], vpfs_out[14]}), 32'h1E);
`else
    chk("t6_ones", $countones(vpfs_out), 2);
    chk("t6_bits", 32'({vpfs_out[189], vpfs_out[190], vpfs_out[10], vpfs_out[11]}), 32'hA);
`endif
    idle();

    // Reset mid-frame: partial frame discarded, no strobe, outputs cleared.
    drive(1, 1, mk(50,0)); drive(0, 1, mk(51,0)); drive(0, 1, mk(52,0));
    @(negedge clock);
    global_reset = 1; frame_start = 0; cluster_valid = 0; cluster_in = '0;
    @(negedge clock);
    global_reset = 0;
    repeat (10) idle();
    chk("mr_valid", 32'(vpfs_valid), 0);
    chk("mr_ones",  $countones(vpfs_out), 0);
    chk("mr_cnt",   32'(cluster_cnt), 0);
    chk("mr_err",   32'(frame_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
